// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx -- memory-mapped UART transmitter with a byte TX FIFO.
//
// Sends 8N1 frames (start bit, 8 data bits LSB first, stop bit) on o_tx.
// Software pushes bytes through the TXDATA register; the FSM pops them and
// shifts them out, one bit per CLKS_PER_BIT enabled cycles.
//
// Register map, decoded on i_addr[4:3]:
//   0 TXDATA  write pushes i_wdata[7:0]; reads as 0
//   1 STATUS  {count[8:4], ovf[3], fsm_busy[2], empty[1], full[0]};
//             any write clears ovf
//   2 CTRL    bit0 tx_en (R/W)
//   3 reserved (reads 0, writes ignored)
//
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset (overrides i_clk_en)
//   i_clk_en  global step enable qualifying every state update
//   i_io_en   IO-region select
//   i_sw      store strobe
//   i_lw      load strobe
//   i_addr    offset inside the IO window (only [4:3] decoded)
//   i_wdata   store data
//   o_rdata   load data (combinational, 0 when no load)
//   o_tx      serial line, idle high
//   o_busy    FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module io_uart_tx #(
    parameter logic [1:0] XLEN         = 2'b10,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    localparam int        DW           = 1 << (int'(XLEN) + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_io_en,
    input  logic          i_sw,
    input  logic          i_lw,
    input  logic [DW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_tx,
    output logic          o_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = 5;
    localparam int BAUD_W = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] SEL_TXDATA = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FSM / shifter state
    state_t              state_r;
    state_t              state_s;
    logic [BAUD_W-1:0]   baud_r;
    logic [BAUD_W-1:0]   baud_s;
    logic [2:0]          bit_idx_r;
    logic [2:0]          bit_idx_s;
    logic [7:0]          shift_r;
    logic [7:0]          shift_s;
    logic                tx_r;
    logic                tx_s;
    logic                pop_s;

    // FIFO state
    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    // Control / status registers
    logic                ovf_r;
    logic                tx_en_r;

    // Bus decode
    logic [1:0]          sel_s;
    logic                wr_s;
    logic                rd_s;
    logic                txdata_wr_s;
    logic                status_wr_s;
    logic                ctrl_wr_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                ovf_set_s;
    logic                baud_done_s;
    logic                fsm_busy_s;
    logic [DW-1:0]       status_s;
    logic [DW-1:0]       rdata_s;
    logic                unused_s;

    assign sel_s       = i_addr[4:3];
    assign wr_s        = i_clk_en & i_io_en & i_sw;
    assign rd_s        = i_io_en & i_lw;
    assign txdata_wr_s = wr_s & (sel_s == SEL_TXDATA);
    assign status_wr_s = wr_s & (sel_s == SEL_STATUS);
    assign ctrl_wr_s   = wr_s & (sel_s == SEL_CTRL);

    // Full/empty come from pre-cycle state, so a pop in the same cycle
    // never makes room for a push, and a push is not seen by the FSM yet.
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign push_s      = txdata_wr_s & ~full_s;
    assign ovf_set_s   = txdata_wr_s & full_s;

    assign baud_done_s = (baud_r == BAUD_LAST);
    assign fsm_busy_s  = (state_r != ST_IDLE);

    // Address and data bits that the register map does not decode.
    assign unused_s = ^{i_addr[DW-1:5], i_addr[2:0], i_wdata[DW-1:8]};

    // FSM next-state, shifter and line-value logic.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                baud_s = {BAUD_W{1'b0}};
                if (tx_en_r && !empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_s    = {BAUD_W{1'b0}};
                    bit_idx_s = 3'd0;
                    tx_s      = shift_r[0];
                    state_s   = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
                        tx_s      = 1'b1;
                        state_s   = ST_STOP;
                    end else begin
                        // Shift right so the next bit is always at [0].
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (tx_en_r && !empty_s) begin
                        // Chain straight into the next frame, no idle gap.
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
                        tx_s    = 1'b0;
                        state_s = ST_START;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                baud_s    = {BAUD_W{1'b0}};
                bit_idx_s = 3'd0;
                tx_s      = 1'b1;
            end
        endcase
    end

    // FSM, baud counter, shifter and line register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else if (i_clk_en) begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
        end
    end

    // FIFO storage; contents need no reset since pointers/count gate them.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && push_s) begin
            mem_r[wr_ptr_r] <= i_wdata[7:0];
        end
    end

    // FIFO pointers (wrap naturally, depth is a power of two) and count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (i_clk_en) begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag (set beats a clearing STATUS write) and tx_en.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_r   <= 1'b0;
            tx_en_r <= 1'b1;
        end else if (i_clk_en) begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (status_wr_s) begin
                ovf_r <= 1'b0;
            end
            if (ctrl_wr_s) begin
                tx_en_r <= i_wdata[0];
            end
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s      = {DW{1'b0}};
        status_s[0]   = full_s;
        status_s[1]   = empty_s;
        status_s[2]   = fsm_busy_s;
        status_s[3]   = ovf_r;
        status_s[8:4] = count_r;
    end

    // Load data mux; zero whenever no load is active.
    always_comb begin
        rdata_s = {DW{1'b0}};
        if (rd_s) begin
            case (sel_s)
                SEL_STATUS: rdata_s = status_s;
                SEL_CTRL:   rdata_s = {{(DW-1){1'b0}}, tx_en_r};
                default:    rdata_s = {DW{1'b0}};
            endcase
        end else begin
            rdata_s = {DW{1'b0}};
        end
    end

    assign o_rdata = rdata_s;
    assign o_tx    = tx_r;
    assign o_busy  = fsm_busy_s | ~empty_s;

endmodule

// File: tb/tb_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_tx -- self-checking bench for io_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=8). Expected serial waveforms are derived from the byte value
// ({stop, data LSB-first, start}) and the count of enabled clock edges; the
// FIFO is modelled as a byte queue.
// -----------------------------------------------------------------------------
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 64;

    localparam logic [63:0] A_TXDATA = 64'h00;
    localparam logic [63:0] A_STATUS = 64'h08;
    localparam logic [63:0] A_CTRL   = 64'h10;
    localparam logic [63:0] A_RSVD   = 64'h18;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clk_en;
    logic          i_io_en;
    logic          i_sw;
    logic          i_lw;
    logic [DW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_tx;
    logic          o_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q [$];
    bit         model_ovf;

    io_uart_tx #(
        .XLEN(2'b10),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clk_en(i_clk_en),
        .i_io_en(i_io_en),
        .i_sw(i_sw),
        .i_lw(i_lw),
        .i_addr(i_addr),
        .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .o_tx(o_tx),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] exp_status(input int cnt, input bit busy, input bit ovf);
        logic [63:0] v;
        v = 64'(cnt) * 64'd16;
        if (ovf)          v = v + 64'd8;
        if (busy)         v = v + 64'd4;
        if (cnt == 0)     v = v + 64'd2;
        if (cnt == DEPTH) v = v + 64'd1;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data);
        i_io_en = 1'b1;
        i_sw    = 1'b1;
        i_addr  = addr;
        i_wdata = data;
        tick();
        i_io_en = 1'b0;
        i_sw    = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, output logic [63:0] data);
        i_io_en = 1'b1;
        i_lw    = 1'b1;
        i_addr  = addr;
        #1;
        data    = o_rdata;
        i_io_en = 1'b0;
        i_lw    = 1'b0;
    endtask

    task automatic check_reg(input logic [63:0] addr, input logic [63:0] exp, input string name);
        logic [63:0] got;
        do_read(addr, got);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Walks a frame from enabled-edge offset k0; the current cycle is the
    // one right after the edge that loaded offset k0.  With toggle set,
    // every other clock edge is disabled.
    task automatic check_frame(input logic [7:0] b, input int k0, input bit toggle, input string name);
        logic [9:0] seq;
        int k;
        int cyc;
        bit en;
        seq = {1'b1, b, 1'b0};
        k   = k0;
        cyc = 0;
        while (k < 10 * CPB) begin
            total++;
            if (o_tx !== seq[k / CPB]) begin
                bad++;
                $display("FAIL %s byte=0x%0h bit=%0d k=%0d tx=%b expected=%b",
                         name, b, k / CPB, k, o_tx, seq[k / CPB]);
            end
            en = toggle ? (cyc % 2 == 1) : 1'b1;
            i_clk_en = en;
            tick();
            if (en) k++;
            cyc++;
        end
        i_clk_en = 1'b1;
    endtask

    task automatic check_idle_line(input int cycles, input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (o_tx !== 1'b1) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s low_cycles=%0d expected=0", name, errs);
        end
    endtask

    task automatic check_bit(input logic got, input logic exp, input string name);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_clk_en = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        check_bit(o_tx, 1'b1, "reset_tx");
        check_bit(o_busy, 1'b0, "reset_busy");
        check_reg(A_STATUS, exp_status(0, 0, 0), "reset_status");
        check_reg(A_CTRL, 64'h1, "reset_ctrl");
        i_io_en = 1'b1;
        i_addr  = A_STATUS;
        #1;
        total++;
        if (o_rdata !== 64'h0) begin
            bad++;
            $display("FAIL rdata_no_load got=0x%0h expected=0x0", o_rdata);
        end
        i_io_en = 1'b0;
    endtask

    task automatic test_single_a5();
        do_write(A_TXDATA, 64'hA5);
        tick();
        check_bit(o_busy, 1'b1, "a5_busy_in_frame");
        check_frame(8'hA5, 0, 1'b0, "a5_frame");
        check_bit(o_busy, 1'b0, "a5_busy_after");
        check_reg(A_STATUS, exp_status(0, 0, 0), "a5_status_after");
    endtask

    task automatic test_reads();
        logic [63:0] got;
        i_io_en = 1'b0;
        i_lw    = 1'b1;
        i_addr  = A_STATUS;
        #1;
        got  = o_rdata;
        i_lw = 1'b0;
        total++;
        if (got !== 64'h0) begin
            bad++;
            $display("FAIL read_no_io_en got=0x%0h expected=0x0", got);
        end
        check_reg(A_RSVD, 64'h0, "read_reserved");
        check_reg(A_TXDATA, 64'h0, "read_txdata");
        do_write(A_RSVD, 64'hFF);
        check_reg(A_STATUS, exp_status(0, 0, 0), "reserved_write_ignored");
        do_write(A_CTRL, 64'hFFFF_FFFF_FFFF_FFFF);
        check_reg(A_CTRL, 64'h1, "ctrl_upper_bits_zero");
        do_write(A_CTRL, 64'hFFFF_FFFF_FFFF_FFFE);
        check_reg(A_CTRL, 64'h0, "ctrl_clear");
        do_write(A_CTRL, 64'h1);
    endtask

    task automatic test_clk_en();
        logic [7:0] b;
        b = 8'($urandom);
        i_clk_en = 1'b0;
        do_write(A_TXDATA, {56'h0, b});
        check_reg(A_STATUS, exp_status(0, 0, 0), "disabled_write_ignored");
        i_clk_en = 1'b1;
        do_write(A_TXDATA, {56'h0, b});
        i_clk_en = 1'b0;
        tick();
        check_bit(o_tx, 1'b1, "disabled_no_pop_tx");
        check_reg(A_STATUS, exp_status(1, 0, 0), "disabled_status_frozen");
        i_clk_en = 1'b1;
        tick();
        check_frame(b, 0, 1'b1, "toggle_frame");
        check_bit(o_busy, 1'b0, "toggle_busy_after");
    endtask

    task automatic test_fill_drain();
        int n;
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 9 : int'($urandom_range(1, 8));
            do_write(A_CTRL, 64'h0);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                do_write(A_TXDATA, {56'h0, b});
                if (model_q.size() < DEPTH) model_q.push_back(b);
                else model_ovf = 1'b1;
            end
            check_reg(A_STATUS, exp_status(model_q.size(), 0, model_ovf), "fill_status");
            if (model_ovf) begin
                do_write(A_STATUS, 64'($urandom));
                model_ovf = 1'b0;
                check_reg(A_STATUS, exp_status(model_q.size(), 0, 0), "ovf_cleared");
            end
            do_write(A_CTRL, 64'h1);
            tick();
            while (model_q.size() > 0) begin
                b = model_q.pop_front();
                check_frame(b, 0, 1'b0, "drain_frame");
            end
            check_bit(o_busy, 1'b0, "drain_busy_after");
            check_reg(A_STATUS, exp_status(0, 0, 0), "drain_status");
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        do_write(A_TXDATA, {56'h0, b0});
        do_write(A_TXDATA, {56'h0, b1});
        repeat (17) tick();
        check_bit(o_tx, b0[3], "mid_frame_bit3");
        i_rst    = 1'b1;
        i_clk_en = 1'b0;
        tick();
        i_rst    = 1'b0;
        i_clk_en = 1'b1;
        check_bit(o_tx, 1'b1, "rst_mid_tx");
        check_bit(o_busy, 1'b0, "rst_mid_busy");
        check_reg(A_STATUS, exp_status(0, 0, 0), "rst_mid_status");
        check_reg(A_CTRL, 64'h1, "rst_mid_ctrl");
        check_idle_line(12 * CPB, "rst_mid_fifo_discarded");
    endtask

    task automatic test_tx_en_clear();
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        do_write(A_TXDATA, {56'h0, b0});
        do_write(A_TXDATA, {56'h0, b1});
        do_write(A_TXDATA, {56'h0, b2});
        repeat (12) tick();
        do_write(A_CTRL, 64'h0);
        check_frame(b0, 14, 1'b0, "txen_clear_frame");
        check_idle_line(15 * CPB, "txen_clear_idle");
        check_reg(A_STATUS, exp_status(2, 0, 0), "txen_clear_status");
        check_reg(A_CTRL, 64'h0, "txen_clear_ctrl");
        do_write(A_CTRL, 64'h1);
        tick();
        check_frame(b1, 0, 1'b0, "resume_frame1");
        check_frame(b2, 0, 1'b0, "resume_frame2");
        check_reg(A_STATUS, exp_status(0, 0, 0), "resume_status");
    endtask

    initial begin
        i_rst     = 1'b1;
        i_clk_en  = 1'b1;
        i_io_en   = 1'b0;
        i_sw      = 1'b0;
        i_lw      = 1'b0;
        i_addr    = 64'h0;
        i_wdata   = 64'h0;
        model_ovf = 1'b0;
        test_reset();
        test_single_a5();
        test_reads();
        test_clk_en();
        test_fill_drain();
        test_reset_mid_frame();
        test_tx_en_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
